hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline.
- Generalises the current unit in four ways: parametrised register-file width; combinational (same-cycle) forwarding; a multi-cycle mul/div (MDU) busy tracker that interlocks HI/LO reads; and data-memory wait-state freezing.
- Sits beside the datapath. Consumes per-stage register indices and control bits. Drives stall, flush and forward selects to the pipeline registers and muxes.
- Adds a saturating stall-cycle counter for performance measurement.

Parameters:
- REG_W, 5, register index width (register 0 is hard-wired zero).
- MDU_LAT, 4, cycles from MDU start until HI/LO is valid (≥1).
- CNT_W, 32, stall-counter width.
- FLUSH_ON_BRANCH, 1, 1 = flush D when a branch is taken; 0 = delay-slot mode.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- BranchD, PCSrcD  in  1,1  branch in D; branch resolved taken
- MfHiLoD  in  1  mfhi/mflo in D
- MduStartE  in  1  mult/div issuing in E
- MemToRegE, RegWriteE  in  1,1  E-stage control
- MemToRegM, RegWriteM, MemAccessM  in  1,1,1  M-stage control
- DmemReady  in  1  data memory completes this cycle
- RegWriteW  in  1  W-stage write enable
- RsD, RtD, RsE, RtE  in  REG_W each  source indices
- WriteRegE, WriteRegM, WriteRegW  in  REG_W each  destination indices
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline register
- FlushD, FlushE, FlushW  out  1 each  insert bubble
- ForwardAD, ForwardBD  out  1,1  M→D branch-compare forward
- ForwardAE, ForwardBE  out  2,2  00 regfile, 01 W, 10 M
- MduBusy  out  1  MDU result pending
- StallCount  out  CNT_W  cycles with StallF=1

Behaviour:
- All hazard, forward, stall and flush outputs are combinational from inputs and internal state. There are no half-cycle or negedge registers.
- Forwarding:
  - ForwardAE = 10 if RegWriteM & RsE≠0 & RsE==WriteRegM; else 01 if the same test holds on the W stage; else 00. M has priority over W.
  - ForwardBE is identical with RtE.
  - ForwardAD = RegWriteM & RsD≠0 & RsD==WriteRegM. ForwardBD is the same with RtD.
- Stall sources:
  - lwstall = MemToRegE & RtE≠0 & (RtE==RsD | RtE==RtD).
  - branchstall = BranchD & [(RegWriteE & WriteRegE≠0 & WriteRegE∈{RsD,RtD}) | (MemToRegM & WriteRegM≠0 & WriteRegM∈{RsD,RtD})].
  - mdustall = MfHiLoD & MduBusy.
  - memstall = MemAccessM & ~DmemReady.
- Priority:
  - memstall=1: StallF=StallD=StallE=StallM=1 and FlushW=1. FlushD=FlushE=0, and all other stalls are masked. The whole pipeline freezes.
  - Else, if (lwstall|branchstall|mdustall): StallF=StallD=1, FlushE=1, and StallE=StallM=FlushW=0.
  - FlushD = FLUSH_ON_BRANCH & PCSrcD & ~StallD.
- MDU FSM, with states IDLE and BUSY and counter cnt, a $clog2(MDU_LAT+1)-bit value:
  - IDLE: on MduStartE & ~memstall, go to BUSY with cnt=MDU_LAT.
  - BUSY: cnt decrements every cycle, including during memstall. When cnt==1 with no new start, return to IDLE.
  - A start accepted while in BUSY restarts with cnt=MDU_LAT; the newest op wins.
  - A start while memstall=1 is ignored because E is frozen. It is accepted on the first cycle in which memstall=0.
  - MduBusy = (state==BUSY).
  - mfhi in D is therefore released in the cycle after cnt reaches 1.
- StallCount:
  - Increments on each clock edge where StallF=1.
  - Saturates at all-ones and never wraps.
- Reset (synchronous, dominates every other input, valid mid-operation): state=IDLE, cnt=0, StallCount=0. MduBusy=0 from the next cycle.
- With no instruction inputs asserted after reset, all combinational outputs are 0 / 00.
- Simultaneous events:
  - memstall combined with lwstall gives memstall behaviour only. lwstall is re-evaluated after the freeze.
  - PCSrcD during a D stall gives no FlushD.

Decomposition:
- Shared package hazard_pkg holds:
  - the fwd_sel_e enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - the mdu_state_e enum (IDLE, BUSY).
- Sub-module mdu_busy_tracker, parametrised on MDU_LAT, contains the FSM and counter.
- The forward and stall logic stays in the top module.

Test Plan:
- add r3,r1,r2 in M, RsE=3, RegWriteM=1; simultaneously WriteRegW=3 → ForwardAE=10. Repeat with RsE=0 → 00.
- lw r5 in E (MemToRegE=1, RtE=5), RsD=5 → StallF=StallD=FlushE=1 and StallE=0. With RsD=6 → all 0.
- MDU_LAT=4: MduStartE pulse at cycle 0; MfHiLoD held high → MduBusy=1 for cycles 1–4, StallD=1 through cycle 4, released at cycle 5.
- MemAccessM=1, DmemReady=0 for 3 cycles while lwstall is also true → StallF..StallM=1 and FlushW=1 for 3 cycles with FlushE=0. Then lwstall behaviour for 1 cycle.
- PCSrcD=1, FLUSH_ON_BRANCH=1, no stall → FlushD=1. Same with branchstall active → FlushD=0.
- Reset asserted mid-BUSY (cnt=2) with StallCount=7 → next cycle MduBusy=0 and StallCount=0. Separately, force StallCount to all-ones with StallF=1 → it stays all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the multi-cycle hazard unit: forward-mux selects and
// the MDU busy-tracker state encoding.
package hazard_pkg;

  // Source select for the E-stage ALU operand muxes.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // MDU result tracker: IDLE means HI/LO is valid, BUSY means a result is pending.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks an in-flight mult/div. A start loads the latency counter; the
// counter runs down every cycle, including frozen ones, because the MDU
// keeps computing while the pipeline is held. A start seen while the
// pipeline is frozen is not an issue yet, so it is ignored until E moves.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  output mdu_state_e state
);

  localparam int CNT_BITS = $clog2(MDU_LAT + 1);
  localparam logic [CNT_BITS-1:0] LAT_VAL = CNT_BITS'(MDU_LAT);
  localparam logic [CNT_BITS-1:0] ONE_VAL = CNT_BITS'(1);

  logic [CNT_BITS-1:0] cnt;
  logic                accept;

  assign accept = start & ~hold;

  // Busy FSM and latency counter; the newest accepted start always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            cnt   <= LAT_VAL;
          end
        end
        BUSY: begin
          if (accept) begin
            cnt <= LAT_VAL;
          end else if (cnt == ONE_VAL) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - ONE_VAL;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: same-cycle forwarding,
// load-use / branch / HI-LO interlocks, data-memory wait-state freeze,
// branch flush and a saturating stall-cycle counter.
//
// Handshake note: the pipeline registers treat StallX as "hold this
// register" and FlushX as "load a bubble"; a data-memory access completes
// in the cycle DmemReady is high, and until then the whole pipe holds.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_W           = 5,
  parameter int MDU_LAT         = 4,
  parameter int CNT_W           = 32,
  parameter int FLUSH_ON_BRANCH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MfHiLoD,
  input  logic             MduStartE,
  input  logic             MemToRegE,
  input  logic             RegWriteE,
  input  logic             MemToRegM,
  input  logic             RegWriteM,
  input  logic             MemAccessM,
  input  logic             DmemReady,
  input  logic             RegWriteW,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  mdu_state_e mdu_state;
  logic       memstall;
  logic       lwstall;
  logic       branchstall;
  logic       mdustall;
  logic       interlock;
  fwd_sel_e   fwd_a;
  fwd_sel_e   fwd_b;

  mdu_busy_tracker #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu (
    .clk  (clk),
    .reset(reset),
    .start(MduStartE),
    .hold (memstall),
    .state(mdu_state)
  );

  assign MduBusy = (mdu_state == BUSY);

  // E-stage operand forwarding; M is the younger result so it wins over W.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (RegWriteM && RsE != ZERO_REG && RsE == WriteRegM)      fwd_a = FWD_M;
    else if (RegWriteW && RsE != ZERO_REG && RsE == WriteRegW) fwd_a = FWD_W;
    if (RegWriteM && RtE != ZERO_REG && RtE == WriteRegM)      fwd_b = FWD_M;
    else if (RegWriteW && RtE != ZERO_REG && RtE == WriteRegW) fwd_b = FWD_W;
  end

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign ForwardAD = RegWriteM & (RsD != ZERO_REG) & (RsD == WriteRegM);
  assign ForwardBD = RegWriteM & (RtD != ZERO_REG) & (RtD == WriteRegM);

  // Stall sources.
  always_comb begin
    memstall    = MemAccessM & ~DmemReady;
    lwstall     = MemToRegE & (RtE != ZERO_REG) & ((RtE == RsD) | (RtE == RtD));
    branchstall = BranchD &
                  ((RegWriteE & (WriteRegE != ZERO_REG) &
                    ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                   (MemToRegM & (WriteRegM != ZERO_REG) &
                    ((WriteRegM == RsD) | (WriteRegM == RtD))));
    mdustall    = MfHiLoD & MduBusy;
    interlock   = lwstall | branchstall | mdustall;
  end

  // Stall/flush resolution; a memory wait freezes everything and masks interlocks.
  always_comb begin
    StallF = memstall | interlock;
    StallD = memstall | interlock;
    StallE = memstall;
    StallM = memstall;
    FlushW = memstall;
    FlushE = ~memstall & interlock;
    FlushD = (FLUSH_ON_BRANCH != 0) & PCSrcD & ~StallD;
  end

  // Saturating count of fetch-stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (StallF && StallCount != {CNT_W{1'b1}}) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule
